// File: rtl/dual_port_bram_512x36.sv
// dual_port_bram_512x36
// True dual-port synchronous RAM, 512 words x 36 bits ({parity, data}).
// Both ports share one clock. Each port has a registered output with its own
// reset value, synchronous set/reset value and write-mode behaviour.
// The storage array is never cleared by reset and powers up all-zero.
module dual_port_bram_512x36 #(
   parameter logic [35:0] INIT_A       = 36'h0,
   parameter logic [35:0] INIT_B       = 36'h0,
   parameter logic [35:0] SRVAL_A      = 36'h0,
   parameter logic [35:0] SRVAL_B      = 36'h0,
   parameter string       WRITE_MODE_A = "WRITE_FIRST",
   parameter string       WRITE_MODE_B = "WRITE_FIRST"
) (
   input  logic        clk,
   input  logic        reset,
   // port A
   input  logic        enA,
   input  logic        ssrA,
   input  logic        weA,
   input  logic [8:0]  addrA,
   input  logic [31:0] diA,
   input  logic [3:0]  dipA,
   output logic [31:0] doA,
   output logic [3:0]  dopA,
   // port B
   input  logic        enB,
   input  logic        ssrB,
   input  logic        weB,
   input  logic [8:0]  addrB,
   input  logic [31:0] diB,
   input  logic [3:0]  dipB,
   output logic [31:0] doB,
   output logic [3:0]  dopB
);

   typedef enum logic [1:0] {
      WM_WRITE_FIRST = 2'd0,
      WM_READ_FIRST  = 2'd1,
      WM_NO_CHANGE   = 2'd2
   } wmode_e;

   // Unrecognised mode strings fall back to WRITE_FIRST.
   localparam wmode_e MODE_A = (WRITE_MODE_A == "READ_FIRST") ? WM_READ_FIRST :
                               (WRITE_MODE_A == "NO_CHANGE")  ? WM_NO_CHANGE  :
                                                                WM_WRITE_FIRST;
   localparam wmode_e MODE_B = (WRITE_MODE_B == "READ_FIRST") ? WM_READ_FIRST :
                               (WRITE_MODE_B == "NO_CHANGE")  ? WM_NO_CHANGE  :
                                                                WM_WRITE_FIRST;

   logic [35:0] mem [0:511] = '{default: '0};

   logic [35:0] word_a;
   logic [35:0] word_b;
   logic [35:0] out_a;
   logic [35:0] out_b;

   assign word_a = {dipA, diA};
   assign word_b = {dipB, diB};

   assign {dopA, doA} = out_a;
   assign {dopB, doB} = out_b;

   // Array writes; port A is applied last so it wins a same-address dual write.
   // Writes are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (enB && weB) mem[addrB] <= word_b;
         if (enA && weA) mem[addrA] <= word_a;
      end
   end

   // Port A output register: sampling mem here sees the pre-edge contents,
   // which gives READ_FIRST and cross-port old-data reads for free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_a <= INIT_A;
      end else if (enA) begin
         if (ssrA) begin
            out_a <= SRVAL_A;
         end else if (weA) begin
            case (MODE_A)
               WM_READ_FIRST: out_a <= mem[addrA];
               WM_NO_CHANGE:  out_a <= out_a;
               default:       out_a <= word_a;
            endcase
         end else begin
            out_a <= mem[addrA];
         end
      end
   end

   // Port B output register, same behaviour as port A.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_b <= INIT_B;
      end else if (enB) begin
         if (ssrB) begin
            out_b <= SRVAL_B;
         end else if (weB) begin
            case (MODE_B)
               WM_READ_FIRST: out_b <= mem[addrB];
               WM_NO_CHANGE:  out_b <= out_b;
               default:       out_b <= word_b;
            endcase
         end else begin
            out_b <= mem[addrB];
         end
      end
   end

endmodule

// File: tb/tb_dual_port_bram_512x36.sv
// Testbench for dual_port_bram_512x36: directed vector table plus hand-written
// sequences for asynchronous reset, write suppression under reset and a full
// address sweep.
module tb_dual_port_bram_512x36;

   localparam logic [35:0] SRVAL_A = 36'h5;
   localparam logic [35:0] SRVAL_B = 36'h9_CAFE_0001;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enA = 1'b0, ssrA = 1'b0, weA = 1'b0;
   logic [8:0]  addrA = '0;
   logic [31:0] diA = '0;
   logic [3:0]  dipA = '0;
   logic [31:0] doA;
   logic [3:0]  dopA;
   logic        enB = 1'b0, ssrB = 1'b0, weB = 1'b0;
   logic [8:0]  addrB = '0;
   logic [31:0] diB = '0;
   logic [3:0]  dipB = '0;
   logic [31:0] doB;
   logic [3:0]  dopB;

   int checks = 0;
   int errors = 0;

   dual_port_bram_512x36 #(
      .INIT_A      (36'h0),
      .INIT_B      (36'h0),
      .SRVAL_A     (SRVAL_A),
      .SRVAL_B     (SRVAL_B),
      .WRITE_MODE_A("WRITE_FIRST"),
      .WRITE_MODE_B("WRITE_FIRST")
   ) dut (
      .clk  (clk),
      .reset(reset),
      .enA  (enA),
      .ssrA (ssrA),
      .weA  (weA),
      .addrA(addrA),
      .diA  (diA),
      .dipA (dipA),
      .doA  (doA),
      .dopA (dopA),
      .enB  (enB),
      .ssrB (ssrB),
      .weB  (weB),
      .addrB(addrB),
      .diB  (diB),
      .dipB (dipB),
      .doB  (doB),
      .dopB (dopB)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  ctl_a;   // {en, ssr, we}
      logic [8:0]  addr_a;
      logic [35:0] din_a;   // {parity, data}
      logic [2:0]  ctl_b;
      logic [8:0]  addr_b;
      logic [35:0] din_b;
      logic [35:0] exp_a;
      logic [35:0] exp_b;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      {enA, ssrA, weA} = v.ctl_a;
      addrA = v.addr_a;
      {dipA, diA} = v.din_a;
      {enB, ssrB, weB} = v.ctl_b;
      addrB = v.addr_b;
      {dipB, diB} = v.din_b;
   endtask

   function automatic vec_t mk(input string n,
                               input logic [2:0] ca, input logic [8:0] aa, input logic [35:0] da,
                               input logic [2:0] cb, input logic [8:0] ab, input logic [35:0] db,
                               input logic [35:0] ea, input logic [35:0] eb);
      vec_t v;
      v.name = n;
      v.ctl_a = ca; v.addr_a = aa; v.din_a = da;
      v.ctl_b = cb; v.addr_b = ab; v.din_b = db;
      v.exp_a = ea; v.exp_b = eb;
      return v;
   endfunction

   initial begin
      // State entering the table: doA = 0 (reset), doB = {1, 00000055}.
      vecs[0]  = mk("wr_a3",      3'b101, 9'd3,  36'hA_DEADBEEF, 3'b000, 9'd0,  36'h0,
                                  36'hA_DEADBEEF, 36'h1_00000055);
      vecs[1]  = mk("rd_b3",      3'b000, 9'd3,  36'h0,          3'b100, 9'd3,  36'h0,
                                  36'hA_DEADBEEF, 36'hA_DEADBEEF);
      vecs[2]  = mk("wr_a20",     3'b101, 9'd20, 36'h0_00002020, 3'b000, 9'd5,  36'h0,
                                  36'h0_00002020, 36'hA_DEADBEEF);
      vecs[3]  = mk("en_low",     3'b001, 9'd20, 36'hF_00000777, 3'b000, 9'd6,  36'h0,
                                  36'h0_00002020, 36'hA_DEADBEEF);
      vecs[4]  = mk("rd_b20",     3'b000, 9'd0,  36'h0,          3'b100, 9'd20, 36'h0,
                                  36'h0_00002020, 36'h0_00002020);
      vecs[5]  = mk("ssr_wr_a7",  3'b111, 9'd7,  36'h3_00001234, 3'b000, 9'd0,  36'h0,
                                  SRVAL_A,        36'h0_00002020);
      vecs[6]  = mk("rd_b7_a3",   3'b100, 9'd3,  36'h0,          3'b100, 9'd7,  36'h0,
                                  36'hA_DEADBEEF, 36'h3_00001234);
      vecs[7]  = mk("pre_a9",     3'b101, 9'd9,  36'h0_00000022, 3'b000, 9'd0,  36'h0,
                                  36'h0_00000022, 36'h3_00001234);
      vecs[8]  = mk("coll_a9",    3'b101, 9'd9,  36'h0_00000011, 3'b100, 9'd9,  36'h0,
                                  36'h0_00000011, 36'h0_00000022);
      vecs[9]  = mk("rd_b9",      3'b000, 9'd0,  36'h0,          3'b100, 9'd9,  36'h0,
                                  36'h0_00000011, 36'h0_00000011);
      vecs[10] = mk("dual_wr0",   3'b101, 9'd0,  36'h0_000000AA, 3'b101, 9'd0,  36'h0_000000BB,
                                  36'h0_000000AA, 36'h0_000000BB);
      vecs[11] = mk("rd_b0",      3'b000, 9'd0,  36'h0,          3'b100, 9'd0,  36'h0,
                                  36'h0_000000AA, 36'h0_000000AA);
      vecs[12] = mk("ssr_ab",     3'b110, 9'd0,  36'h0,          3'b110, 9'd0,  36'h0,
                                  SRVAL_A,        SRVAL_B);
      vecs[13] = mk("ssr_no_en",  3'b010, 9'd3,  36'h0,          3'b010, 9'd3,  36'h0,
                                  SRVAL_A,        SRVAL_B);
      vecs[14] = mk("rd_a7_b3",   3'b100, 9'd7,  36'h0,          3'b100, 9'd3,  36'h0,
                                  36'h3_00001234, 36'hA_DEADBEEF);
      vecs[15] = mk("pre_a30",    3'b101, 9'd30, 36'h5_30303030, 3'b000, 9'd0,  36'h0,
                                  36'h5_30303030, 36'hA_DEADBEEF);

      // Power-on reset: outputs take INIT values without a clock edge.
      #2 reset = 1'b1;
      #1;
      check("por_a", {dopA, doA}, 36'h0);
      check("por_b", {dopB, doB}, 36'h0);
      @(negedge clk);
      reset = 1'b0;

      // Write addr 5, read it back, then reset mid-cycle.
      enA = 1'b1; weA = 1'b1; addrA = 9'd5; {dipA, diA} = 36'h1_00000055;
      step();
      check("wr_a5", {dopA, doA}, 36'h1_00000055);
      enA = 1'b0; weA = 1'b0;
      enB = 1'b1; addrB = 9'd5;
      step();
      check("rd_b5", {dopB, doB}, 36'h1_00000055);
      enB = 1'b0;
      #3 reset = 1'b1;
      #1;
      check("mid_rst_a", {dopA, doA}, 36'h0);
      check("mid_rst_b", {dopB, doB}, 36'h0);
      #1 reset = 1'b0;
      enB = 1'b1; addrB = 9'd5;
      step();
      check("rd_b5_after_rst", {dopB, doB}, 36'h1_00000055);

      // Directed table.
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i]);
         step();
         check({vecs[i].name, "_a"}, {dopA, doA}, vecs[i].exp_a);
         check({vecs[i].name, "_b"}, {dopB, doB}, vecs[i].exp_b);
      end

      // A write attempted across an edge while reset is held must be dropped.
      enB = 1'b0; ssrB = 1'b0; weB = 1'b0;
      #2 reset = 1'b1;
      enA = 1'b1; ssrA = 1'b0; weA = 1'b1; addrA = 9'd30; {dipA, diA} = 36'hF_FFFFFFFF;
      step();
      check("rst_hold_a", {dopA, doA}, 36'h0);
      #2 reset = 1'b0;
      enA = 1'b0; weA = 1'b0;
      enB = 1'b1; addrB = 9'd30;
      step();
      check("rst_no_write", {dopB, doB}, 36'h5_30303030);

      // Full sweep: write every address through A, read back through B.
      enB = 1'b0;
      for (int i = 0; i < 512; i++) begin
         enA = 1'b1; weA = 1'b1; addrA = 9'(i);
         diA = 32'(i) ^ 32'h5A5A5A5A; dipA = 4'(i);
         step();
      end
      enA = 1'b0; weA = 1'b0;
      for (int i = 0; i < 512; i++) begin
         enB = 1'b1; addrB = 9'(i);
         step();
         check($sformatf("sweep_%0d", i), {dopB, doB}, {4'(i), 32'(i) ^ 32'h5A5A5A5A});
      end
      // Address wrap: 511 followed by 0.
      addrB = 9'd0;
      step();
      check("wrap_0", {dopB, doB}, {4'h0, 32'h5A5A5A5A});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
